// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl
//   Owns the write port and the async read port of the single instruction
//   memory. After reset the CPU is held stopped. A host loader streams a
//   program in word by word over a valid/ready handshake. The controller then
//   releases the CPU and passes fetch reads straight through to the memory.
//
// Ports
//   clk, reset           rising-edge clock, synchronous active-high reset
//   ld_start, ld_len     (re)load request and its word count
//   ld_valid, ld_data    host word stream
//   ld_ready             a word is accepted this cycle when ld_valid is high
//   mem_we, mem_waddr,
//   mem_wdata            instruction memory write port
//   mem_raddr, mem_rdata instruction memory async read port
//   fetch_addr           byte PC from the fetch stage
//   fetch_inst           instruction to the IF/ID register (0 = NOP)
//   cpu_run              CPU may advance; 0 holds the pipeline
//   busy                 load in progress
//   done                 one-cycle pulse on the first RUN cycle after a load
//   err                  sticky error, cleared by an accepted ld_start
module imem_load_ctrl #(
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_start,
  input  logic [AW:0]   ld_len,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_wdata,
  output logic [AW-1:0] mem_raddr,
  input  logic [DW-1:0] mem_rdata,
  input  logic [31:0]   fetch_addr,
  output logic [DW-1:0] fetch_inst,
  output logic          cpu_run,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  localparam logic [AW:0] DEPTH_W     = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE     = {{AW{1'b0}}, 1'b1};
  localparam logic [31:0] FETCH_LIMIT = 32'(DEPTH * 4);

  state_t      state, state_n;
  logic [AW:0] cnt, cnt_n;
  logic [AW:0] len, len_n;
  logic        err_n, done_n;
  logic        err_set, err_clr;
  logic        accept;
  logic        len_ok, len_zero;
  logic        fetch_bad;

  // cnt is one bit wider than the address so a full DEPTH-word load
  // finishes without the counter wrapping.
  assign len_ok    = (ld_len <= DEPTH_W);
  assign len_zero  = (ld_len == '0);
  assign fetch_bad = (fetch_addr >= FETCH_LIMIT) || (fetch_addr[1:0] != 2'b00);

  // Reset gates the handshake so no word slips into memory on the reset edge.
  assign accept = (state == LOAD) && ld_valid && !reset;

  // State register plus the counter, latched length and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      len   <= '0;
      err   <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      len   <= len_n;
      err   <= err_n;
      done  <= done_n;
    end
  end

  // Next-state logic. A load request is honoured from IDLE and RUN but ignored
  // while a load is already in flight. A zero-length request just (re)starts
  // the CPU on whatever the memory already holds.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    len_n   = len;
    done_n  = 1'b0;
    err_set = 1'b0;
    err_clr = 1'b0;
    case (state)
      IDLE, RUN: begin
        if (ld_start) begin
          if (!len_ok) begin
            err_set = 1'b1;
          end else begin
            err_clr = 1'b1;
            if (len_zero) begin
              state_n = RUN;
              done_n  = 1'b1;
            end else begin
              state_n = LOAD;
              cnt_n   = '0;
              len_n   = ld_len;
            end
          end
        end
        if (state == RUN && fetch_bad) begin
          err_set = 1'b1;
        end
      end
      LOAD: begin
        if (accept) begin
          cnt_n = cnt + CNT_ONE;
          if (cnt == len - CNT_ONE) begin
            state_n = RUN;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    // A new error in the same cycle as a clear wins, so err stays set.
    if (err_set) begin
      err_n = 1'b1;
    end else if (err_clr) begin
      err_n = 1'b0;
    end else begin
      err_n = err;
    end
  end

  // Outputs. Fetch reads pass through with zero latency in RUN only; a bad
  // fetch address returns a NOP instead of an aliased or truncated word.
  always_comb begin
    ld_ready   = (state == LOAD) && !reset;
    mem_we     = accept;
    mem_waddr  = cnt[AW-1:0];
    mem_wdata  = ld_data;
    busy       = (state == LOAD);
    cpu_run    = (state == RUN);
    mem_raddr  = '0;
    fetch_inst = '0;
    if (state == RUN) begin
      mem_raddr = fetch_addr[AW+1:2];
      if (!fetch_bad) begin
        fetch_inst = mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Testbench for imem_load_ctrl. Memory writes are checked by a scoreboard
// monitor against queued expected (address, data) pairs; status and fetch
// outputs are checked directly against hand-computed constants.
module tb_imem_load_ctrl;

  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          ld_start;
  logic [AW:0]   ld_len;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_ready;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata;
  logic [31:0]   fetch_addr;
  logic [DW-1:0] fetch_inst;
  logic          cpu_run;
  logic          busy;
  logic          done;
  logic          err;

  int vectors = 0;
  int miscompares = 0;

  logic [AW+DW-1:0] exp_q[$];
  logic [DW-1:0]    tb_mem [DEPTH];
  logic [DW-1:0]    prog [7];

  imem_load_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .ld_start(ld_start), .ld_len(ld_len),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .fetch_addr(fetch_addr), .fetch_inst(fetch_inst),
    .cpu_run(cpu_run), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Instruction memory model: synchronous write, async read, never cleared.
  initial begin
    for (int i = 0; i < DEPTH; i++) tb_mem[i] = '0;
  end
  always @(posedge clk) begin
    if (mem_we === 1'b1) tb_mem[mem_waddr] <= mem_wdata;
  end
  assign mem_rdata = tb_mem[mem_raddr];

  // Scoreboard monitor: every write the DUT presents must match the next
  // expected entry.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_write: got addr=%0d data=%08h, required no write",
                 mem_waddr, mem_wdata);
      end else begin
        logic [AW+DW-1:0] e;
        e = exp_q.pop_front();
        if ({mem_waddr, mem_wdata} !== e) begin
          miscompares++;
          $display("[TB] FAIL write: got addr=%0d data=%08h, required addr=%0d data=%08h",
                   mem_waddr, mem_wdata, e[AW+DW-1:DW], e[DW-1:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic start, input logic [AW:0] len,
                               input logic valid, input logic [DW-1:0] data,
                               input logic [31:0] faddr);
    ld_start   = start;
    ld_len     = len;
    ld_valid   = valid;
    ld_data    = data;
    fetch_addr = faddr;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %08h, required %08h", name, actual, expected);
    end
  endtask

  task automatic expectWrite(input int addr, input logic [DW-1:0] data);
    logic [AW-1:0] a;
    a = AW'(addr);
    exp_q.push_back({a, data});
  endtask

  task automatic checkFetch(input string name, input logic [31:0] faddr,
                            input logic [DW-1:0] expected);
    fetch_addr = faddr;
    #1;
    checkOutput(name, fetch_inst, expected);
  endtask

  initial begin
    logic [1:0] vpat;
    int         k;
    prog[0] = 32'h00000820; prog[1] = 32'h00001020; prog[2] = 32'h20090064;
    prog[3] = 32'h10290002; prog[4] = 32'h20210001; prog[5] = 32'h08000003;
    prog[6] = 32'h00221820;

    reset = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, '0, 32'h0);
    tick(); tick();
    reset = 1'b0;
    checkOutput("reset_cpu_run", {31'b0, cpu_run}, 32'd0);
    checkOutput("reset_busy",    {31'b0, busy},    32'd0);
    checkOutput("reset_done",    {31'b0, done},    32'd0);
    checkOutput("reset_err",     {31'b0, err},     32'd0);
    checkOutput("reset_ready",   {31'b0, ld_ready},32'd0);
    checkOutput("reset_inst",    fetch_inst,       32'd0);

    // 7-word program, ld_valid already high on the start cycle.
    for (int i = 0; i < 7; i++) expectWrite(i, prog[i]);
    applyStimulus(1'b1, 6'd7, 1'b1, prog[0], 32'h0);
    tick();
    checkOutput("load7_busy",    {31'b0, busy},     32'd1);
    checkOutput("load7_ready",   {31'b0, ld_ready}, 32'd1);
    checkOutput("load7_cpu_run", {31'b0, cpu_run},  32'd0);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 6'd0, 1'b1, prog[i], 32'h0);
      tick();
    end
    applyStimulus(1'b0, 6'd0, 1'b0, '0, 32'h0);
    checkOutput("load7_done",    {31'b0, done},    32'd1);
    checkOutput("load7_cpu_run", {31'b0, cpu_run}, 32'd1);
    checkFetch("load7_fetch14", 32'h14, 32'h08000003);
    tick();
    checkOutput("load7_done_once", {31'b0, done}, 32'd0);
    checkOutput("load7_err",       {31'b0, err},  32'd0);

    // 3-word reload from RUN with ld_valid toggling; gap data must not land.
    for (int i = 0; i < 3; i++) expectWrite(i, 32'hA000_0000 + i);
    applyStimulus(1'b1, 6'd3, 1'b0, '0, 32'h0);
    tick();
    checkOutput("tog_cpu_run_drop", {31'b0, cpu_run}, 32'd0);
    k = 0;
    for (int c = 0; c < 5; c++) begin
      vpat = (c % 2 == 0) ? 2'b01 : 2'b00;
      checkOutput("tog_ready", {31'b0, ld_ready}, 32'd1);
      applyStimulus(1'b0, 6'd0, vpat[0], vpat[0] ? 32'hA000_0000 + k : 32'hDEAD_0000, 32'h0);
      if (vpat[0]) k++;
      tick();
    end
    applyStimulus(1'b0, 6'd0, 1'b0, '0, 32'h0);
    checkOutput("tog_ready_off", {31'b0, ld_ready}, 32'd0);
    checkOutput("tog_done",      {31'b0, done},     32'd1);
    checkFetch("tog_fetch0", 32'h0, 32'hA000_0000);
    checkFetch("tog_fetch8", 32'h8, 32'hA000_0002);
    checkFetch("tog_fetchC", 32'hC, prog[3]);

    // Fetch faults in RUN: out of range, then misaligned.
    checkFetch("oob_inst", 32'h80, 32'h0);
    tick();
    checkOutput("oob_err", {31'b0, err}, 32'd1);
    applyStimulus(1'b1, 6'd0, 1'b0, '0, 32'h0);
    tick();
    applyStimulus(1'b0, 6'd0, 1'b0, '0, 32'h0);
    checkOutput("restart_err_clr", {31'b0, err},  32'd0);
    checkOutput("restart_done",    {31'b0, done}, 32'd1);
    checkFetch("mis_inst", 32'h6, 32'h0);
    tick();
    checkOutput("mis_err", {31'b0, err}, 32'd1);
    fetch_addr = 32'h0;

    // Back to IDLE, oversize request, then a full-depth load.
    reset = 1'b1; tick(); reset = 1'b0;
    applyStimulus(1'b1, 6'd33, 1'b1, 32'hBAD0_0000, 32'h0);
    tick();
    applyStimulus(1'b0, 6'd0, 1'b0, '0, 32'h0);
    checkOutput("len33_err",     {31'b0, err},      32'd1);
    checkOutput("len33_busy",    {31'b0, busy},     32'd0);
    checkOutput("len33_cpu_run", {31'b0, cpu_run},  32'd0);
    checkOutput("len33_ready",   {31'b0, ld_ready}, 32'd0);
    for (int i = 0; i < 32; i++) expectWrite(i, 32'h1000_0000 + i);
    applyStimulus(1'b1, 6'd32, 1'b0, '0, 32'h0);
    tick();
    checkOutput("len32_err_clr", {31'b0, err}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 6'd0, 1'b1, 32'h1000_0000 + i, 32'h0);
      tick();
    end
    applyStimulus(1'b0, 6'd0, 1'b0, '0, 32'h7C);
    checkOutput("len32_done",    {31'b0, done},    32'd1);
    checkOutput("len32_cpu_run", {31'b0, cpu_run}, 32'd1);
    checkFetch("len32_last", 32'h7C, 32'h1000_001F);
    tick();
    checkOutput("len32_err", {31'b0, err}, 32'd0);

    // Reset after 2 of 5 words, with the host still presenting word 2.
    expectWrite(0, 32'h5000_0000);
    expectWrite(1, 32'h5000_0001);
    applyStimulus(1'b1, 6'd5, 1'b0, '0, 32'h0);
    tick();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 6'd0, 1'b1, 32'h5000_0000 + i, 32'h0);
      tick();
    end
    applyStimulus(1'b0, 6'd0, 1'b1, 32'h5000_0002, 32'h0);
    reset = 1'b1; tick(); reset = 1'b0;
    checkOutput("rst_cpu_run", {31'b0, cpu_run}, 32'd0);
    checkOutput("rst_busy",    {31'b0, busy},    32'd0);
    tick(); tick();
    applyStimulus(1'b1, 6'd0, 1'b0, '0, 32'h0);
    tick();
    applyStimulus(1'b0, 6'd0, 1'b0, '0, 32'h0);
    checkOutput("len0_done",    {31'b0, done},    32'd1);
    checkOutput("len0_cpu_run", {31'b0, cpu_run}, 32'd1);
    checkFetch("len0_word0", 32'h0, 32'h5000_0000);
    checkFetch("len0_word1", 32'h4, 32'h5000_0001);
    checkFetch("len0_word2", 32'h8, 32'h1000_0002);

    // 2-word reload from RUN; a start pulse mid-load must be ignored.
    expectWrite(0, 32'h6000_0000);
    expectWrite(1, 32'h6000_0001);
    applyStimulus(1'b1, 6'd2, 1'b0, '0, 32'h0);
    tick();
    checkOutput("rl_cpu_run_drop", {31'b0, cpu_run}, 32'd0);
    applyStimulus(1'b1, 6'd33, 1'b1, 32'h6000_0000, 32'h0);
    tick();
    applyStimulus(1'b0, 6'd0, 1'b1, 32'h6000_0001, 32'h0);
    tick();
    applyStimulus(1'b0, 6'd0, 1'b0, '0, 32'h0);
    checkOutput("rl_cpu_run", {31'b0, cpu_run}, 32'd1);
    checkOutput("rl_err",     {31'b0, err},     32'd0);
    checkFetch("rl_word0", 32'h0, 32'h6000_0000);
    checkFetch("rl_word1", 32'h4, 32'h6000_0001);
    checkFetch("rl_word2", 32'h8, 32'h1000_0002);

    tick(); tick();
    checkOutput("pending_writes", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imem_load_ctrl.md
Name: imem_load_ctrl

Overview:
- Controller that owns the port pair of the single instruction memory (one write port, one async read port). It sequences the memory between a host program-loader and the CPU fetch stage.
- After reset it holds the CPU stopped. It loads a program word-by-word through a valid/ready handshake, then releases the CPU and passes fetch reads through.
- It sits between the IF stage/PC and the instruction memory array; it replaces hard-coded initial program contents.

Parameters:
- DEPTH, 32, number of 32-bit instruction words in memory.
- AW, 5, word-address width (log2 DEPTH).
- DW, 32, instruction width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- ld_start  in  1  one-cycle pulse: begin a (re)load of ld_len words.
- ld_len  in  AW+1  word count for the load, sampled when ld_start is accepted.
- ld_valid  in  1  host word valid.
- ld_data  in  DW  host instruction word.
- ld_ready  out  1  controller accepts a word this cycle.
- mem_we  out  1  write enable to instruction memory.
- mem_waddr  out  AW  write word address.
- mem_wdata  out  DW  write data.
- mem_raddr  out  AW  read word address.
- mem_rdata  in  DW  async read data from memory.
- fetch_addr  in  32  byte PC from the fetch stage.
- fetch_inst  out  DW  instruction to the IF/ID register.
- cpu_run  out  1  CPU may advance the PC; 0 = hold pipeline.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse, first cycle of RUN after a load.
- err  out  1  sticky error flag; cleared by an accepted ld_start.

Behaviour:
- States: IDLE, LOAD, RUN. reset -> IDLE. All registered outputs are 0 after reset: cpu_run, busy, done, err, and the word counter cnt.
- IDLE:
  - ld_start with 1 <= ld_len <= DEPTH -> LOAD; cnt=0, len latched, err cleared.
  - ld_start with ld_len == 0 -> RUN with no writes (existing contents run); done pulses.
  - ld_start with ld_len > DEPTH -> err=1, stay IDLE, no writes.
- LOAD:
  - ld_ready=1 and busy=1.
  - A word is accepted when ld_valid & ld_ready. On acceptance, mem_we=1 combinationally that cycle, mem_waddr=cnt, mem_wdata=ld_data, and cnt increments.
  - The accept with cnt == len-1 -> RUN next cycle; done=1 in that first RUN cycle only.
  - If ld_valid is low, nothing is written and the controller keeps waiting with no timeout.
  - ld_start while in LOAD is ignored.
- RUN:
  - cpu_run=1; ld_ready=0, mem_we=0.
  - mem_raddr = fetch_addr[AW+1:2]; fetch_inst = mem_rdata combinationally (zero-latency, same as async memory).
  - fetch_addr >= DEPTH*4 -> fetch_inst = 0 (NOP) and err set next cycle. No address wrap-around.
  - fetch_addr[1:0] != 0 -> fetch_inst = 0 and err set. The bits are not silently truncated.
  - ld_start in RUN -> same length checks as IDLE. A valid length goes to LOAD, with cpu_run dropping on the next edge. An invalid length sets err and stays in RUN.
- Outside RUN: fetch_inst = 0 and mem_raddr = 0. cpu_run=0 in IDLE and LOAD.
- Simultaneous events:
  - ld_valid on the same cycle as ld_start is not accepted; acceptance begins the cycle after entering LOAD.
  - reset has priority over everything.
- Reset mid-LOAD: -> IDLE, cnt=0, no further writes. Words already written stay in memory; the controller never clears memory.
- err: sticky until the next accepted ld_start (valid length). An error event in the same cycle as a clear leaves err set.
- cnt width is AW+1 so that len == DEPTH completes without overflow.

Test Plan:
- Reset, then ld_start with ld_len=7, feeding the 7-word loop program (0x00000820, 0x00001020, 0x20090064, 0x10290002, 0x20210001, 0x08000003, 0x00221820) with ld_valid held high -> writes to addresses 0..6 on consecutive cycles. done pulses once, cpu_run=1 the next cycle, fetch_addr=0x14 gives fetch_inst=0x08000003.
- Load of 3 words with ld_valid toggling 1,0,1,0,1 -> exactly 3 writes at addresses 0,1,2 and no write in the gap cycles. ld_ready stays 1 until the third accept.
- ld_len=33 (DEPTH=32) -> err=1, state IDLE, mem_we never asserted. Then ld_len=32 full load -> last write at address 31, RUN entered, err=0.
- In RUN: fetch_addr=0x80 -> fetch_inst=0 and err=1. fetch_addr=0x06 -> fetch_inst=0 and err=1.
- Assert reset after 2 of 5 words -> IDLE, cpu_run=0, busy=0, and no further writes. ld_start with ld_len=0 -> RUN, done pulses, and words 0..1 read back as loaded.
- In RUN, ld_start with ld_len=2 -> cpu_run=0 the next cycle, 2 words are overwritten, then RUN resumes with the new contents visible on fetch.
